// File: rtl/sia_rxq_v2_pkg.sv
// Shared constants and FSM encoding for the SIA receive queue.
package sia_rxq_v2_pkg;

  localparam int SIA_BITS_W = 5;
  localparam logic [SIA_BITS_W-1:0] SIA_BITS_8N1 = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_PUSH  = 2'd3
  } state_t;

endpackage

// File: rtl/sia_rxq_fifo.sv
// Receive frame FIFO: RAM, pointers, level, status flags, overflow policy and sticky overrun.
module sia_rxq_fifo #(
  parameter int DATA_BITS  = 12,
  parameter int DEPTH_BITS = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  push_i,
  input  logic [DATA_BITS-1:0]  data_i,
  input  logic                  ferr_i,
  input  logic                  pop_i,
  input  logic                  ovwr_i,
  input  logic [DEPTH_BITS:0]   thresh_i,
  input  logic                  ovr_clr_i,
  output logic [DATA_BITS-1:0]  head_dat_o,
  output logic                  head_ferr_o,
  output logic [DEPTH_BITS:0]   level_o,
  output logic                  not_empty_o,
  output logic                  full_o,
  output logic                  hiwat_o,
  output logic                  ovr_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int LW    = DEPTH_BITS + 1;
  localparam logic [DEPTH_BITS:0] FULL_LVL = DEPTH[DEPTH_BITS:0];

  logic [DATA_BITS:0]    ram_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic                  pop_eff, full_now, overrun, do_write, rd_adv;
  logic                  not_empty_q, full_q, hiwat_q, ovr_q;

  // Decide what this cycle's push/pop does to the queue.
  always_comb begin
    pop_eff  = pop_i && (level_q != '0);
    full_now = (level_q == FULL_LVL);
    // A pop on a full queue frees a slot first, so it never counts as overrun.
    overrun  = push_i && full_now && !pop_eff;
    do_write = push_i && (!overrun || ovwr_i);
    rd_adv   = pop_eff || (overrun && ovwr_i);
    level_d  = level_q + LW'(push_i && !overrun) - LW'(pop_eff);
  end

  // Frame storage.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      // NOTE: RAM is cleared by reset so the head read after reset is a defined 0.
      for (int i = 0; i < DEPTH; i++) ram_q[i] <= '0;
    end else if (do_write) begin
      ram_q[wr_ptr_q] <= {ferr_i, data_i};
    end
  end

  // Pointers, level, flags registered from the next-state level, sticky overrun.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      not_empty_q <= 1'b0;
      full_q      <= 1'b0;
      hiwat_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_adv)   rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      not_empty_q <= (level_d != '0);
      full_q      <= (level_d == FULL_LVL);
      hiwat_q     <= (level_d >= thresh_i);
      if (overrun)        ovr_q <= 1'b1;
      else if (ovr_clr_i) ovr_q <= 1'b0;
    end
  end

  assign head_dat_o  = ram_q[rd_ptr_q][DATA_BITS-1:0];
  assign head_ferr_o = ram_q[rd_ptr_q][DATA_BITS];
  assign level_o     = level_q;
  assign not_empty_o = not_empty_q;
  assign full_o      = full_q;
  assign hiwat_o     = hiwat_q;
  assign ovr_o       = ovr_q;

endmodule

// File: rtl/sia_rxq_v2.sv
// SIA receive path: pin synchronisers, async/sync frame deserialiser, and frame FIFO.
module sia_rxq_v2
  import sia_rxq_v2_pkg::*;
#(
  parameter int SHIFT_REG_WIDTH = 12,
  parameter int BAUD_RATE_WIDTH = 32,
  parameter int DEPTH_BITS      = 2,
  parameter int DATA_BITS       = 12
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [SIA_BITS_W-1:0]      bits_i,
  input  logic [BAUD_RATE_WIDTH-1:0] baud_i,
  input  logic                       sync_i,
  input  logic                       rxcpol_i,
  input  logic                       ovwr_i,
  input  logic [DEPTH_BITS:0]        thresh_i,
  input  logic                       rxd_i,
  input  logic                       rxc_i,
  input  logic                       rxq_pop_i,
  input  logic                       rxq_oe_i,
  input  logic                       ovr_clr_i,
  output logic [DATA_BITS-1:0]       rxq_dat_o,
  output logic                       rxq_ferr_o,
  output logic [DEPTH_BITS:0]        rxq_level_o,
  output logic                       rxq_not_empty_o,
  output logic                       rxq_full_o,
  output logic                       rxq_hiwat_o,
  output logic                       rxq_ovr_o
);

  localparam int W = SHIFT_REG_WIDTH;

  state_t                     state_q, state_d;
  logic [1:0]                 rxd_sync_q, rxc_sync_q;
  logic                       rxd_q, rxc_q, rxd_s, rxc_s;
  logic                       rxd_fall, rxc_rise, rxc_fall, edge_idle, edge_cfg;
  logic [BAUD_RATE_WIDTH-1:0] cnt_q, cfg_baud_q;
  logic [SIA_BITS_W-1:0]      bitcnt_q, cfg_bits_q;
  logic                       cfg_sync_q, cfg_pol_q;
  logic [W-1:0]               shreg_q;
  logic                       start_frame, shift_en, cnt_ld_half, cnt_ld_full, cnt_dec, push;
  logic                       last_bit;
  logic [DATA_BITS-1:0]       head_dat;
  logic                       head_ferr;

  // Two-flop synchronisers plus one delayed copy for edge detection; the line idles high.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rxd_sync_q <= 2'b11;
      rxc_sync_q <= 2'b00;
      rxd_q      <= 1'b1;
      rxc_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
      rxd_sync_q <= {rxd_sync_q[0], rxd_i};
      rxc_sync_q <= {rxc_sync_q[0], rxc_i};
      rxd_q      <= rxd_sync_q[1];
      rxc_q      <= rxc_sync_q[1];
    end
  end

  assign rxd_s     = rxd_sync_q[1];
  assign rxc_s     = rxc_sync_q[1];
  assign rxd_fall  = rxd_q & ~rxd_s;
  assign rxc_rise  = rxc_s & ~rxc_q;
  assign rxc_fall  = ~rxc_s & rxc_q;
  assign edge_idle = rxcpol_i ? rxc_fall : rxc_rise;
  assign edge_cfg  = cfg_pol_q ? rxc_fall : rxc_rise;
  assign last_bit  = (bitcnt_q + 5'd1) >= cfg_bits_q;

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // FSM next state and datapath strobes.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d     = state_q;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    cnt_ld_half = 1'b0;
    cnt_ld_full = 1'b0;
    cnt_dec     = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!sync_i) begin
          if (rxd_fall) begin
            start_frame = 1'b1;
            cnt_ld_half = 1'b1;
            state_d     = ST_START;
          end
        end else if (edge_idle && !rxd_s) begin
          start_frame = 1'b1;
          shift_en    = 1'b1;
          state_d     = ST_DATA;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (rxd_s) begin
            state_d = ST_IDLE;
          end else begin
            shift_en    = 1'b1;
            cnt_ld_full = 1'b1;
            state_d     = ST_DATA;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DATA: begin
        if (cfg_sync_q) begin
          if (edge_cfg) begin
            shift_en = 1'b1;
            if (last_bit) state_d = ST_PUSH;
          end
        end else if (cnt_q == '0) begin
          shift_en    = 1'b1;
          cnt_ld_full = 1'b1;
          if (last_bit) state_d = ST_PUSH;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Config capture at frame start, baud counter, bit counter and shift register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cfg_bits_q <= '0;
      cfg_baud_q <= '0;
      cfg_sync_q <= 1'b0;
      cfg_pol_q  <= 1'b0;
      cnt_q      <= '0;
      bitcnt_q   <= '0;
      shreg_q    <= '1;
    end else begin
      if (start_frame) begin
        cfg_bits_q <= bits_i;
        cfg_baud_q <= baud_i;
        cfg_sync_q <= sync_i;
        cfg_pol_q  <= rxcpol_i;
      end
      if (cnt_ld_half)      cnt_q <= baud_i >> 1;
      else if (cnt_ld_full) cnt_q <= cfg_baud_q;
      else if (cnt_dec)     cnt_q <= cnt_q - 1'b1;
      if (start_frame) begin
        bitcnt_q <= shift_en ? 5'd1 : 5'd0;
        shreg_q  <= shift_en ? {rxd_s, {(W-1){1'b1}}} : '1;
      end else if (shift_en) begin
        bitcnt_q <= bitcnt_q + 5'd1;
        shreg_q  <= {rxd_s, shreg_q[W-1:1]};
      end
    end
  end

  sia_rxq_fifo #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .push_i      (push),
    .data_i      (shreg_q),
    .ferr_i      (~shreg_q[W-1]),
    .pop_i       (rxq_pop_i),
    .ovwr_i      (ovwr_i),
    .thresh_i    (thresh_i),
    .ovr_clr_i   (ovr_clr_i),
    .head_dat_o  (head_dat),
    .head_ferr_o (head_ferr),
    .level_o     (rxq_level_o),
    .not_empty_o (rxq_not_empty_o),
    .full_o      (rxq_full_o),
    .hiwat_o     (rxq_hiwat_o),
    .ovr_o       (rxq_ovr_o)
  );

  assign rxq_dat_o  = rxq_oe_i ? head_dat : '0;
  assign rxq_ferr_o = rxq_oe_i & head_ferr;

endmodule

// File: tb/tb_sia_rxq_v2.sv
// Directed bench for sia_rxq_v2: 50 MHz clock, 1 us bit period, depth 4.
module tb_sia_rxq_v2;
  import sia_rxq_v2_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic [4:0]  bits_i = SIA_BITS_8N1;
  logic [31:0] baud_i = 32'd49;
  logic        sync_i = 1'b0, rxcpol_i = 1'b0, ovwr_i = 1'b0;
  logic [2:0]  thresh_i = 3'd5;
  logic        rxd_i = 1'b1, rxc_i = 1'b0;
  logic        rxq_pop_i = 1'b0, rxq_oe_i = 1'b1, ovr_clr_i = 1'b0;
  logic [11:0] rxq_dat_o;
  logic        rxq_ferr_o;
  logic [2:0]  rxq_level_o;
  logic        rxq_not_empty_o, rxq_full_o, rxq_hiwat_o, rxq_ovr_o;

  int checks = 0;
  int errors = 0;

  // Raw 12-bit words: {stop, data MSB..LSB, start, two preset ones}.
  localparam logic [11:0] W_A1 = 12'hD0B;
  localparam logic [11:0] W_85 = 12'hC2B;
  localparam logic [11:0] W_3C = 12'h9E3;
  localparam logic [11:0] W_55_BADSTOP = 12'h2AB;

  sia_rxq_v2 u_dut (
    .clk_i           (clk_i),
    .reset_ni        (reset_ni),
    .bits_i          (bits_i),
    .baud_i          (baud_i),
    .sync_i          (sync_i),
    .rxcpol_i        (rxcpol_i),
    .ovwr_i          (ovwr_i),
    .thresh_i        (thresh_i),
    .rxd_i           (rxd_i),
    .rxc_i           (rxc_i),
    .rxq_pop_i       (rxq_pop_i),
    .rxq_oe_i        (rxq_oe_i),
    .ovr_clr_i       (ovr_clr_i),
    .rxq_dat_o       (rxq_dat_o),
    .rxq_ferr_o      (rxq_ferr_o),
    .rxq_level_o     (rxq_level_o),
    .rxq_not_empty_o (rxq_not_empty_o),
    .rxq_full_o      (rxq_full_o),
    .rxq_hiwat_o     (rxq_hiwat_o),
    .rxq_ovr_o       (rxq_ovr_o)
  );

  always #10 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // Drive one async frame LSB first; optionally pop in the exact cycle the DUT pushes.
  task automatic send_async(input logic [9:0] f, input bit pop_at_push);
    bit hit;
    for (int i = 0; i < 10; i++) begin
      rxd_i = f[i];
      if (i == 9 && pop_at_push) begin
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
          @(negedge clk_i);
          if (u_dut.state_q == ST_PUSH) begin
            rxq_pop_i = 1'b1;
            @(negedge clk_i);
            rxq_pop_i = 1'b0;
            hit = 1'b1;
          end
        end
        check("push_seen", {31'd0, hit}, 32'd1);
      end
      #1000;
    end
    rxd_i = 1'b1;
    #2000;
    @(negedge clk_i);
  endtask

  // Sync frame: data changes with rising rxc, DUT samples on falling rxc.
  task automatic send_sync(input logic [9:0] f);
    for (int i = 0; i < 10; i++) begin
      rxd_i = f[i];
      rxc_i = 1'b1;
      #500;
      rxc_i = 1'b0;
      #500;
    end
    rxd_i = 1'b1;
    #2000;
    @(negedge clk_i);
  endtask

  task automatic pop_one();
    @(negedge clk_i);
    rxq_pop_i = 1'b1;
    @(negedge clk_i);
    rxq_pop_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk_i);
    ovr_clr_i = 1'b1;
    @(negedge clk_i);
    ovr_clr_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    // 1: reset, pops on empty queue
    #100;
    @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);
    check("rst_dat", rxq_dat_o, 0);
    check("rst_level", rxq_level_o, 0);
    check("rst_not_empty", rxq_not_empty_o, 0);
    check("rst_full", rxq_full_o, 0);
    check("rst_ovr", rxq_ovr_o, 0);
    for (int i = 0; i < 4; i++) pop_one();
    @(negedge clk_i);
    check("empty_pop_level", rxq_level_o, 0);
    check("empty_pop_dat", rxq_dat_o, 0);

    // 2: four async frames fill the queue, then drain it
    send_async(frame(8'hA1, 1'b1), 1'b0);
    check("f1_level", rxq_level_o, 1);
    check("f1_dat", rxq_dat_o, W_A1);
    check("f1_ferr", rxq_ferr_o, 0);
    check("f1_not_empty", rxq_not_empty_o, 1);
    send_async(frame(8'h85, 1'b1), 1'b0);
    check("f2_level", rxq_level_o, 2);
    send_async(frame(8'hA1, 1'b1), 1'b0);
    check("f3_level", rxq_level_o, 3);
    check("f3_full", rxq_full_o, 0);
    send_async(frame(8'h85, 1'b1), 1'b0);
    check("f4_level", rxq_level_o, 4);
    check("f4_full", rxq_full_o, 1);
    check("f4_hiwat_thresh_gt_depth", rxq_hiwat_o, 0);
    check("f4_head", rxq_dat_o, W_A1);
    rxq_oe_i = 1'b0;
    #1;
    check("oe_off_dat", rxq_dat_o, 0);
    rxq_oe_i = 1'b1;
    pop_one();
    check("pop1_dat", rxq_dat_o, W_85);
    check("pop1_level", rxq_level_o, 3);
    check("pop1_full", rxq_full_o, 0);
    pop_one();
    check("pop2_dat", rxq_dat_o, W_A1);
    pop_one();
    check("pop3_dat", rxq_dat_o, W_85);
    pop_one();
    check("pop4_level", rxq_level_o, 0);
    check("pop4_not_empty", rxq_not_empty_o, 0);
    check("pop4_wrap_stale", rxq_dat_o, W_A1);

    // 3: overflow policies
    send_async(frame(8'hA1, 1'b1), 1'b0);
    send_async(frame(8'h85, 1'b1), 1'b0);
    send_async(frame(8'hA1, 1'b1), 1'b0);
    send_async(frame(8'h85, 1'b1), 1'b0);
    check("refill_ovr", rxq_ovr_o, 0);
    ovwr_i = 1'b0;
    send_async(frame(8'h3C, 1'b1), 1'b0);
    check("drop_level", rxq_level_o, 4);
    check("drop_head", rxq_dat_o, W_A1);
    check("drop_ovr", rxq_ovr_o, 1);
    pulse_clr();
    check("clr_ovr", rxq_ovr_o, 0);
    ovwr_i = 1'b1;
    send_async(frame(8'h3C, 1'b1), 1'b0);
    check("ovwr_head", rxq_dat_o, W_85);
    check("ovwr_level", rxq_level_o, 4);
    check("ovwr_ovr", rxq_ovr_o, 1);
    pop_one();
    pop_one();
    pop_one();
    check("ovwr_tail", rxq_dat_o, W_3C);
    check("ovwr_tail_level", rxq_level_o, 1);
    pop_one();
    pulse_clr();
    ovwr_i = 1'b0;

    // 4: framing error, then a glitch that must not push
    send_async(frame(8'h55, 1'b0), 1'b0);
    check("ferr_level", rxq_level_o, 1);
    check("ferr_dat", rxq_dat_o, W_55_BADSTOP);
    check("ferr_flag", rxq_ferr_o, 1);
    pop_one();
    rxd_i = 1'b0;
    #400;
    rxd_i = 1'b1;
    #3000;
    @(negedge clk_i);
    check("glitch_level", rxq_level_o, 0);
    check("glitch_idle", {31'd0, u_dut.state_q == ST_IDLE}, 1);
    send_async(frame(8'hA1, 1'b1), 1'b0);
    check("post_glitch_dat", rxq_dat_o, W_A1);
    check("post_glitch_ferr", rxq_ferr_o, 0);
    pop_one();

    // 5: synchronous mode on falling rxc, high-water threshold
    sync_i   = 1'b1;
    rxcpol_i = 1'b1;
    thresh_i = 3'd2;
    send_sync(frame(8'hA1, 1'b1));
    check("sync1_level", rxq_level_o, 1);
    check("sync1_dat", rxq_dat_o, W_A1);
    check("sync1_hiwat", rxq_hiwat_o, 0);
    send_sync(frame(8'hA1, 1'b1));
    check("sync2_level", rxq_level_o, 2);
    check("sync2_hiwat", rxq_hiwat_o, 1);
    thresh_i = 3'd0;
    @(negedge clk_i);
    @(negedge clk_i);
    check("thresh0_hiwat", rxq_hiwat_o, 1);
    thresh_i = 3'd5;
    sync_i   = 1'b0;
    rxcpol_i = 1'b0;
    @(negedge clk_i);

    // 6: pop coincident with push on a full queue, then reset mid-frame
    send_async(frame(8'h85, 1'b1), 1'b0);
    send_async(frame(8'h85, 1'b1), 1'b0);
    check("pre_coinc_full", rxq_full_o, 1);
    send_async(frame(8'h3C, 1'b1), 1'b1);
    check("coinc_level", rxq_level_o, 4);
    check("coinc_ovr", rxq_ovr_o, 0);
    check("coinc_head", rxq_dat_o, W_A1);
    begin
      logic [9:0] f;
      f = frame(8'hA1, 1'b1);
      for (int i = 0; i < 4; i++) begin
        rxd_i = f[i];
        #1000;
      end
    end
    reset_ni = 1'b0;
    rxd_i    = 1'b1;
    #100;
    @(negedge clk_i);
    reset_ni = 1'b1;
    #12000;
    @(negedge clk_i);
    check("midrst_level", rxq_level_o, 0);
    check("midrst_not_empty", rxq_not_empty_o, 0);
    check("midrst_dat", rxq_dat_o, 0);
    check("midrst_ovr", rxq_ovr_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
